seg_display_ctrl: RTL and testbench

Parametrised seven-segment display controller, successor to the fixed six-digit lab display driver. Shows an arithmetic result in decimal (unsigned or signed, optional leading-zero blanking) or hexadecimal across `NUM_DIGITS` digits. Binary-to-BCD conversion is a sequential double-dabble engine with a double-buffered digit register. Button-triggered "rEG xx" / "CodE  x" overlays time out after a parametrised number of milliseconds. It sits between the ALU result/operand registers and the board HEX outputs, and uses one `hex_driver` per digit.

---
 rtl/seg_display_ctrl_if.sv | 30 +++
 rtl/seg_display_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seg_display_ctrl_if.sv
// Bundle between the ALU result/operand registers and the seven-segment
// controller: display mode controls, overlay requests, segment outputs.
interface seg_display_ctrl_if #(
    parameter int NUM_DIGITS = 6,
    parameter int RESULT_W   = 24
);
    logic                    oneMsPulse;
    logic                    dispMode;
    logic                    signedMode;
    logic                    blankLZ;
    logic [RESULT_W-1:0]     OpResult;
    logic [7:0]              OpReg;
    logic                    ShowOpReg;
    logic [2:0]              OpCode;
    logic                    ShowOpCode;
    logic [8*NUM_DIGITS-1:0] HEX;
    logic                    convBusy;

    modport master (
        output oneMsPulse, dispMode, signedMode, blankLZ,
        output OpResult, OpReg, ShowOpReg, OpCode, ShowOpCode,
        input  HEX, convBusy
    );

    modport slave (
        input  oneMsPulse, dispMode, signedMode, blankLZ,
        input  OpResult, OpReg, ShowOpReg, OpCode, ShowOpCode,
        output HEX, convBusy
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// Seven-segment display controller: sequential double-dabble BCD engine,
// double-buffered digits, hex mode and timed register/opcode overlays.
module hex_driver (
    input  logic [4:0] char_i,
    output logic [7:0] seg_o
);
    // Character code to active-low segment byte, decimal point off
    always_comb begin
        seg_o = 8'hFF;
        case (char_i)
            5'h00: seg_o = 8'hC0;
            5'h01: seg_o = 8'hF9;
            5'h02: seg_o = 8'hA4;
            5'h03: seg_o = 8'hB0;
            5'h04: seg_o = 8'h99;
            5'h05: seg_o = 8'h92;
            5'h06: seg_o = 8'h82;
            5'h07: seg_o = 8'hF8;
            5'h08: seg_o = 8'h80;
            5'h09: seg_o = 8'h90;
            5'h0A: seg_o = 8'h88;
            5'h0B: seg_o = 8'h83;
            5'h0C: seg_o = 8'hC6;
            5'h0D: seg_o = 8'hA1;
            5'h0E: seg_o = 8'h86;
            5'h0F: seg_o = 8'h8E;
            5'h10: seg_o = 8'hAF;
            5'h11: seg_o = 8'hA3;
            5'h12: seg_o = 8'hC2;
            5'h14: seg_o = 8'hBF;
            default: seg_o = 8'hFF;
        endcase
    end
endmodule

module seg_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int RESULT_W   = 24,
    parameter int TIMEOUT_MS = 3000
) (
    input logic               clk,
    input logic               rst_n,
    seg_display_ctrl_if.slave bus
);
    localparam int BCD_D = 10;
    localparam int CW    = $clog2(TIMEOUT_MS + 1);
    localparam int SW    = $clog2(RESULT_W + 1);
    localparam int PADW  = (RESULT_W > 4 * NUM_DIGITS) ? RESULT_W : 4 * NUM_DIGITS;

    localparam logic [4:0] CHAR_R     = 5'h10;
    localparam logic [4:0] CHAR_O     = 5'h11;
    localparam logic [4:0] CHAR_G     = 5'h12;
    localparam logic [4:0] CHAR_BLANK = 5'h13;
    localparam logic [4:0] CHAR_MINUS = 5'h14;

    typedef enum logic [1:0] {SHOW_RESULT, SHOW_OPREG, SHOW_OPCODE} disp_e;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} bcd_e;

    disp_e                   disp_q, disp_d;
    logic [CW-1:0]           tmo_q, tmo_d;
    bcd_e                    bst_q, bst_d;
    logic [RESULT_W-1:0]     snap_q, snap_d;
    logic                    snap_sgn_q, snap_sgn_d;
    logic [RESULT_W-1:0]     mag_q, mag_d;
    logic                    neg_q, neg_d;
    logic [4*BCD_D-1:0]      acc_q, acc_d;
    logic [SW-1:0]           scnt_q, scnt_d;
    logic [4*NUM_DIGITS-1:0] buf_dig_q, buf_dig_d;
    logic                    buf_neg_q, buf_neg_d;
    logic                    buf_ovf_q, buf_ovf_d;
    logic                    buf_smode_q, buf_smode_d;

    logic [4*BCD_D-1:0]      adj;
    logic                    ovf;
    logic [PADW-1:0]         hex_src;
    logic [4:0]              chr [NUM_DIGITS];
    logic [4:0]              dchr;
    int                      msd;

    // Overlay selection: opcode request wins, requests restart the timeout
    always_comb begin
        disp_d = disp_q;
        tmo_d  = tmo_q;
        if (bus.ShowOpCode) begin
            disp_d = SHOW_OPCODE;
            tmo_d  = '0;
        end else if (bus.ShowOpReg) begin
            disp_d = SHOW_OPREG;
            tmo_d  = '0;
        end else if (disp_q != SHOW_RESULT && bus.oneMsPulse) begin
            if (tmo_q == CW'(TIMEOUT_MS - 1)) begin
                disp_d = SHOW_RESULT;
                tmo_d  = '0;
            end else begin
                tmo_d = tmo_q + CW'(1);
            end
        end
    end

    // Double-dabble engine; display buffer only changes in DONE
    always_comb begin
        bst_d       = bst_q;
        snap_d      = snap_q;
        snap_sgn_d  = snap_sgn_q;
        mag_d       = mag_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        scnt_d      = scnt_q;
        buf_dig_d   = buf_dig_q;
        buf_neg_d   = buf_neg_q;
        buf_ovf_d   = buf_ovf_q;
        buf_smode_d = buf_smode_q;
        adj         = acc_q;
        ovf         = 1'b0;
        for (int i = 0; i < BCD_D; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            if (i >= NUM_DIGITS - int'(neg_q) && acc_q[4*i +: 4] != 4'd0)
                ovf = 1'b1;
        end
        case (bst_q)
            IDLE: begin
                if (bus.OpResult != snap_q || bus.signedMode != snap_sgn_q)
                    bst_d = LOAD;
            end
            LOAD: begin
                snap_d     = bus.OpResult;
                snap_sgn_d = bus.signedMode;
                if (bus.signedMode && bus.OpResult[RESULT_W-1]) begin
                    mag_d = -bus.OpResult;
                    neg_d = 1'b1;
                end else begin
                    mag_d = bus.OpResult;
                    neg_d = 1'b0;
                end
                acc_d  = '0;
                scnt_d = '0;
                bst_d  = SHIFT;
            end
            SHIFT: begin
                acc_d  = (adj << 1) | {{(4*BCD_D-1){1'b0}}, mag_q[RESULT_W-1]};
                mag_d  = mag_q << 1;
                scnt_d = scnt_q + SW'(1);
                if (scnt_q == SW'(RESULT_W - 1))
                    bst_d = DONE;
            end
            DONE: begin
                buf_dig_d   = acc_q[4*NUM_DIGITS-1:0];
                buf_neg_d   = neg_q;
                buf_ovf_d   = ovf;
                buf_smode_d = snap_sgn_q;
                bst_d       = IDLE;
            end
            default: bst_d = IDLE;
        endcase
    end

    // Per-digit character selection from overlay, hex input or BCD buffer
    always_comb begin
        hex_src = PADW'(bus.OpResult);
        msd     = 0;
        dchr    = CHAR_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            chr[i] = CHAR_BLANK;
            if (buf_dig_q[4*i +: 4] != 4'd0)
                msd = i;
        end
        case (disp_q)
            SHOW_OPREG: begin
                chr[5] = CHAR_R;
                chr[4] = 5'h0E;
                chr[3] = CHAR_G;
                chr[1] = {1'b0, bus.OpReg[7:4]};
                chr[0] = {1'b0, bus.OpReg[3:0]};
            end
            SHOW_OPCODE: begin
                chr[5] = 5'h0C;
                chr[4] = CHAR_O;
                chr[3] = 5'h0D;
                chr[2] = 5'h0E;
                chr[0] = {2'b00, bus.OpCode};
            end
            default: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    dchr = {1'b0, buf_dig_q[4*i +: 4]};
                    if (bus.dispMode)
                        chr[i] = {1'b0, hex_src[4*i +: 4]};
                    else if (buf_ovf_q)
                        chr[i] = CHAR_MINUS;
                    else if (bus.blankLZ) begin
                        if (i <= msd)
                            chr[i] = dchr;
                        else if (i == msd + 1 && buf_neg_q)
                            chr[i] = CHAR_MINUS;
                        else
                            chr[i] = CHAR_BLANK;
                    end else if (i == NUM_DIGITS - 1 && buf_neg_q)
                        chr[i] = CHAR_MINUS;
                    else if (i == NUM_DIGITS - 1 && buf_smode_q)
                        chr[i] = CHAR_BLANK;
                    else
                        chr[i] = dchr;
                end
            end
        endcase
    end

    // State registers for overlay FSM, BCD engine and display buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q      <= SHOW_RESULT;
            tmo_q       <= '0;
            bst_q       <= IDLE;
            snap_q      <= '0;
            snap_sgn_q  <= 1'b0;
            mag_q       <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            scnt_q      <= '0;
            buf_dig_q   <= '0;
            buf_neg_q   <= 1'b0;
            buf_ovf_q   <= 1'b0;
            buf_smode_q <= 1'b0;
        end else begin
            disp_q      <= disp_d;
            tmo_q       <= tmo_d;
            bst_q       <= bst_d;
            snap_q      <= snap_d;
            snap_sgn_q  <= snap_sgn_d;
            mag_q       <= mag_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            scnt_q      <= scnt_d;
            buf_dig_q   <= buf_dig_d;
            buf_neg_q   <= buf_neg_d;
            buf_ovf_q   <= buf_ovf_d;
            buf_smode_q <= buf_smode_d;
        end
    end

    assign bus.convBusy = (bst_q != IDLE);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        hex_driver u_hex (
            .char_i (chr[g]),
            .seg_o  (bus.HEX[8*g +: 8])
        );
    end
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: vector table for formatting,
// hand sequences for latency, overlays, reset and mid-conversion churn.
module tb_seg_display_ctrl;
    localparam int N = 6;
    localparam int W = 24;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    seg_display_ctrl_if #(.NUM_DIGITS(N), .RESULT_W(W)) bus ();

    seg_display_ctrl #(.NUM_DIGITS(N), .RESULT_W(W), .TIMEOUT_MS(3000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dm;
        logic        sm;
        logic        bl;
        logic [23:0] val;
        int          wt;
        logic [47:0] exp;
    } vec_t;

    vec_t vt [13];

    localparam logic [47:0] ZERO_BL = 48'hFF_FF_FF_FF_FF_C0;
    localparam logic [47:0] OPREG_5A = 48'hAF_86_C2_FF_92_88;

    task automatic check(input string nm, input logic [47:0] act,
                         input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ms_tick();
        bus.oneMsPulse = 1'b1;
        tick();
        bus.oneMsPulse = 1'b0;
        tick();
    endtask

    initial begin
        vt[0]  = '{1'b0, 1'b0, 1'b1, 24'h0F4240, 30, 48'hBF_BF_BF_BF_BF_BF};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 24'd42,     30, 48'hC0_C0_C0_C0_99_A4};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 24'd42,      0, 48'hFF_FF_FF_FF_99_A4};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 24'hFFFF85, 30, 48'hFF_FF_BF_F9_A4_B0};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 24'hFFFF85,  0, 48'hBF_C0_C0_F9_A4_B0};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 24'd42,     30, 48'hFF_C0_C0_C0_99_A4};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 24'd0,      30, ZERO_BL};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 24'hFFFFFF, 30, 48'hFF_FF_FF_FF_BF_F9};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 24'hFE7960, 30, 48'hBF_BF_BF_BF_BF_BF};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 24'hFE7961, 30, 48'hBF_90_90_90_90_90};
        vt[10] = '{1'b0, 1'b0, 1'b1, 24'h0F423F, 30, 48'h90_90_90_90_90_90};
        vt[11] = '{1'b1, 1'b0, 1'b0, 24'hABC123,  0, 48'h88_83_C6_F9_A4_B0};
        vt[12] = '{1'b1, 1'b1, 1'b1, 24'h00000F,  0, 48'hC0_C0_C0_C0_C0_8E};

        rst_n          = 1'b0;
        bus.oneMsPulse = 1'b0;
        bus.dispMode   = 1'b0;
        bus.signedMode = 1'b0;
        bus.blankLZ    = 1'b1;
        bus.OpResult   = '0;
        bus.OpReg      = '0;
        bus.ShowOpReg  = 1'b0;
        bus.OpCode     = '0;
        bus.ShowOpCode = 1'b0;
        repeat (3) tick();
        check("reset_hex", bus.HEX, ZERO_BL);
        check("reset_busy", 48'(bus.convBusy), 48'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_hex", bus.HEX, ZERO_BL);

        bus.OpResult = 24'd123456;
        repeat (26) tick();
        check("lat26_old", bus.HEX, ZERO_BL);
        check("lat26_busy", 48'(bus.convBusy), 48'd1);
        tick();
        check("lat27_new", bus.HEX, 48'hF9_A4_B0_99_92_82);
        check("lat27_idle", 48'(bus.convBusy), 48'd0);

        for (int i = 0; i < 13; i++) begin
            bus.dispMode   = vt[i].dm;
            bus.signedMode = vt[i].sm;
            bus.blankLZ    = vt[i].bl;
            bus.OpResult   = vt[i].val;
            if (vt[i].wt == 0)
                #1;
            else
                repeat (vt[i].wt) tick();
            check($sformatf("vec%0d", i), bus.HEX, vt[i].exp);
        end

        bus.OpReg     = 8'h5A;
        bus.ShowOpReg = 1'b1;
        tick();
        bus.ShowOpReg = 1'b0;
        check("opreg_show", bus.HEX, OPREG_5A);
        for (int k = 0; k < 2000; k++) ms_tick();
        check("opreg_2000", bus.HEX, OPREG_5A);
        bus.ShowOpReg = 1'b1;
        tick();
        bus.ShowOpReg = 1'b0;
        for (int k = 0; k < 2999; k++) ms_tick();
        check("opreg_4999", bus.HEX, OPREG_5A);
        ms_tick();
        check("opreg_5000", bus.HEX, 48'hC0_C0_C0_C0_C0_8E);

        bus.OpCode     = 3'd3;
        bus.ShowOpReg  = 1'b1;
        bus.ShowOpCode = 1'b1;
        tick();
        bus.ShowOpReg  = 1'b0;
        bus.ShowOpCode = 1'b0;
        check("opcode_both", bus.HEX, 48'hC6_A3_A1_86_FF_B0);

        bus.dispMode = 1'b0;
        bus.blankLZ  = 1'b1;
        rst_n = 1'b0;
        #2;
        check("rst_ovl_hex", bus.HEX, ZERO_BL);
        check("rst_ovl_busy", 48'(bus.convBusy), 48'd0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("conv_busy", 48'(bus.convBusy), 48'd1);
        rst_n = 1'b0;
        #2;
        check("rst_conv_busy", 48'(bus.convBusy), 48'd0);
        check("rst_conv_hex", bus.HEX, ZERO_BL);
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check("post_rst_15", bus.HEX, 48'hFF_FF_FF_FF_F9_92);

        bus.OpResult = 24'h01B207;
        repeat (30) tick();
        check("churn_base", bus.HEX, 48'hF9_F9_F9_F9_F9_F9);
        for (int j = 0; j < 4; j++) begin
            case (j)
                0: bus.OpResult = 24'h03640E;
                1: bus.OpResult = 24'h051615;
                2: bus.OpResult = 24'h06C81C;
                default: bus.OpResult = 24'h087A23;
            endcase
            for (int c = 0; c < 5; c++) begin
                tick();
                total++;
                if (!(bus.HEX == 48'hF9_F9_F9_F9_F9_F9 ||
                      bus.HEX == 48'hA4_A4_A4_A4_A4_A4)) begin
                    bad++;
                    $display("FAIL churn_partial: got %h want 111111/222222",
                             bus.HEX);
                end
            end
        end
        for (int c = 0; c < 60; c++) begin
            tick();
            total++;
            if (!(bus.HEX == 48'hF9_F9_F9_F9_F9_F9 ||
                  bus.HEX == 48'hA4_A4_A4_A4_A4_A4 ||
                  bus.HEX == 48'h92_92_92_92_92_92)) begin
                bad++;
                $display("FAIL churn_settle: got %h want 111111/222222/555555",
                         bus.HEX);
            end
        end
        check("churn_final", bus.HEX, 48'h92_92_92_92_92_92);
        check("churn_idle", 48'(bus.convBusy), 48'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
